mem_requester: RTL and testbench
================================

Name: mem_requester

Overview:
- Initiator-side engine for one requester port of the 4-port round-robin memory controller (256 x 8 memory).
- Accepts read/write commands from a local client into a small command FIFO and arbitrates via req/ack.
- Once granted, issues up to MAX_BURST single-cycle transactions on the shared memory bus, then releases the port.
- Returns read data to the client as one-cycle response pulses. One instance per port (req_0..req_3).

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
MAX_BURST, 4, max transactions per grant before req is dropped for fairness (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  client command present
cmd_ready  out  1  FIFO can accept (= not full)
cmd_rw  in  1  1 = read, 0 = write
cmd_addr  in  8  command address
cmd_wdata  in  8  write data (ignored for reads)
rsp_valid  out  1  one-cycle read-data pulse
rsp_rdata  out  8  read data
rsp_addr  out  8  address of returned read
req  out  1  arbitration request to controller
ack  in  1  grant from controller
mem_valid  out  1  transaction strobe on shared bus
mem_rw  out  1  1 = read, 0 = write
mem_addr  out  8  bus address
mem_wdata  out  8  bus write data
mem_rdata  in  8  controller read data (combinational from address when mem_rw = 1)
busy  out  1  state != IDLE or FIFO not empty

Behaviour:
- Reset values: req 0, mem_valid 0, mem_rw 0, mem_addr 0, mem_wdata 0, rsp_valid 0, rsp_rdata 0, rsp_addr 0, busy 0, cmd_ready 1, FIFO empty, state IDLE, beat_cnt 0.
- Reset mid-operation drops req and flushes the FIFO. Pending commands are lost.
- Shared-bus rule: mem_valid, mem_rw, mem_addr and mem_wdata are all-zero unless mem_valid = 1. This lets the four instances be OR-combined.
- mem_valid = (state == XFER) & ack & !empty. When mem_valid = 1, the bus fields are taken from the FIFO head.
- FIFO:
  - push = cmd_valid & cmd_ready; pop = mem_valid.
  - Push and pop in the same cycle are legal.
  - cmd_ready = !full, so push while full is impossible.
  - Occupancy counter width is $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- FSM states: IDLE, REQ, XFER, RELEASE.
  - IDLE: req 0. Go to REQ when !empty.
  - REQ: req 1. Go to XFER when ack = 1. The arbiter registers the grant, so ack arrives >=1 cycle after req rises.
  - XFER: req 1. Each cycle with ack & !empty, pop one command and increment beat_cnt.
  - XFER -> RELEASE when the pop makes the FIFO empty, or when beat_cnt reaches MAX_BURST-1 on a pop. Clear beat_cnt on this transition.
  - XFER -> REQ if ack falls while in XFER (protocol violation tolerated). No pop that cycle; beat_cnt is kept.
  - RELEASE: req 0. Go to IDLE when ack = 0. The controller drops ack one cycle after req falls.
- Write latency: the memory updates in the same cycle as mem_valid with mem_rw = 0.
- Read response:
  - At the clock edge ending a cycle with mem_valid & mem_rw, capture mem_rdata and mem_addr.
  - rsp_valid is high the following cycle for exactly 1 cycle.
  - No backpressure on responses. Back-to-back reads give back-to-back pulses.
  - Writes produce no response.
- Ordering: strict FIFO order. A read after a write to the same address returns the new data.

Decomposition:
- Package mem_req_pkg holds:
  - typedef mem_cmd_t packed struct {rw, addr[7:0], wdata[7:0]}
  - enum req_state_e {IDLE, REQ, XFER, RELEASE}
  - constants RW_READ = 1'b1, RW_WRITE = 1'b0, ADDR_W = 8, DATA_W = 8
- Sub-module mem_req_fifo: synchronous FIFO of mem_cmd_t, parameter DEPTH, with push, pop, head, full and empty outputs.
- The top level contains the FSM, beat counter, bus gating and response register.

Test Plan:
- Write then read:
  - Stimulus: push write addr 0x10 data 0xA5, then read 0x10.
  - Required: req rises, ack is modelled 1 cycle later, two consecutive mem_valid beats (rw 0 then 1), rsp_valid pulse with rsp_rdata 0xA5 and rsp_addr 0x10, then req falls.
- Burst limit (MAX_BURST = 4):
  - Stimulus: push 6 reads (addresses 0x00..0x05).
  - Required: 4 mem_valid beats, req low, ack drops, req re-asserted, 2 more beats, responses in address order.
- FIFO full (DEPTH = 4, ack held 0):
  - Stimulus: push 5 commands.
  - Required: cmd_ready low after the 4th push, 5th not accepted; all 4 issued in order once ack is given.
- Ack lost mid-XFER:
  - Stimulus: deassert ack after 1 beat of a 3-command queue.
  - Required: mem_valid 0 and all bus fields 0 that cycle, FSM in REQ; on re-ack the remaining 2 commands issue.
- Reset mid-burst:
  - Stimulus: assert rst during the 2nd beat.
  - Required: next cycle req 0, mem_valid 0, rsp_valid 0, busy 0, cmd_ready 1; no further beats without new pushes.
- Idle bus:
  - Stimulus: no commands for 20 cycles.
  - Required: req, mem_valid, mem_addr, mem_wdata and mem_rw all 0 throughout.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and constants for the memory requester.
// Holds the command struct stored in the command FIFO, the FSM state
// encoding, and the bus field widths.
package mem_req_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } req_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous command FIFO of mem_cmd_t entries.
// Ports:
//   clk, rst      clock, synchronous active-high reset (flushes contents)
//   push, cmd     write cmd when push is high (caller guarantees !full)
//   pop           advance head when high (caller guarantees !empty)
//   head          oldest entry, valid while !empty
//   full, empty   occupancy flags
//   count         occupancy, 0..DEPTH
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  mem_cmd_t                 cmd,
  input  logic                     pop,
  output mem_cmd_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  mem_cmd_t        store [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_r;

  // Storage needs no reset; entries are only observed while !empty.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= cmd;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = store[rd_ptr];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/mem_requester.sv
// Initiator-side engine for one port of the round-robin memory controller.
// Client commands are queued in a FIFO; the FSM requests the port, issues
// up to MAX_BURST single-cycle bus transactions per grant, then releases.
// Read data returns as one-cycle rsp_valid pulses, in command order.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      client command handshake (cmd_rw/addr/wdata)
//   rsp_valid/rdata/addr     one-cycle read response, no backpressure
//   req/ack                  arbitration request and grant
//   mem_valid/rw/addr/wdata  shared bus; all fields zero when idle so the
//                            four port instances can be OR-combined
//   mem_rdata                read data from controller (combinational)
//   busy                     FSM active or commands pending
//   dbg_state                current FSM state
//
// Handshake: a command transfers on any clock edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on registered state.
module mem_requester
  import mem_req_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              req,
  input  logic              ack,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output req_state_e        dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  req_state_e     state;
  logic [BW-1:0]  beat_cnt;
  mem_cmd_t       cmd_in;
  mem_cmd_t       head;
  logic           push;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  logic           last_entry;

  assign cmd_in    = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !full;
  assign push      = cmd_valid & !full;

  mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .cmd   (cmd_in),
    .pop   (mem_valid),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A beat issues only while granted; bus fields are gated to zero otherwise.
  assign mem_valid = (state == XFER) & ack & !empty;
  assign mem_rw    = mem_valid & head.rw;
  assign mem_addr  = mem_valid ? head.addr  : '0;
  assign mem_wdata = mem_valid ? head.wdata : '0;

  // The pop this cycle empties the FIFO unless a push lands alongside it.
  assign last_entry = (count == CW'(1)) & !push;

  assign busy      = (state != IDLE) | !empty;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req      <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        REQ: begin
          if (ack) state <= XFER;
        end
        XFER: begin
          if (!ack) begin
            // Grant withdrawn early: re-request and keep the burst count.
            state <= REQ;
          end else if (empty || last_entry || (beat_cnt == LAST_BEAT)) begin
            state    <= RELEASE;
            req      <= 1'b0;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        RELEASE: begin
          if (!ack) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  // Read data is captured at the end of the read beat and presented for
  // exactly the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_addr  <= '0;
    end else begin
      rsp_valid <= mem_valid & mem_rw;
      if (mem_valid & mem_rw) begin
        rsp_rdata <= mem_rdata;
        rsp_addr  <= mem_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Directed and randomized checks for mem_requester against a reference
// built from the command stream: an ordered list of expected bus beats
// and a reference memory giving each read's expected data.
module tb_mem_requester;
  import mem_req_pkg::*;

  localparam int DEPTH     = 4;
  localparam int MAX_BURST = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata, rsp_addr;
  logic       req, ack;
  logic       mem_valid, mem_rw;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       busy;
  req_state_e dbg_state;

  mem_requester #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_addr  (rsp_addr),
    .req       (req),
    .ack       (ack),
    .mem_valid (mem_valid),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- environment: arbiter + memory ----------------
  logic [7:0] bus_mem [256];
  logic       ack_en;
  assign mem_rdata = bus_mem[mem_addr];

  // Grant is a registered copy of req (gated by ack_en); writes commit
  // before the next beat can read them.
  initial begin : env
    logic       s_req, s_wr, s_rst;
    logic [7:0] s_addr, s_data;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      s_req  = req;
      s_rst  = rst;
      s_wr   = mem_valid & ~mem_rw;
      s_addr = mem_addr;
      s_data = mem_wdata;
      @(posedge clk);
      #2;
      ack = s_req & ack_en & ~s_rst;
      if (s_wr && !s_rst) bus_mem[s_addr] = s_data;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [16:0] exp_cmd_q[$];   // {rw, addr, wdata} in issue order
  logic [15:0] exp_rsp_q[$];   // {addr, rdata} in response order
  logic [7:0]  ref_mem [256];
  int          grant_q[$];
  int          grant_beats = 0;
  logic        req_q = 1'b0;
  mem_cmd_t    mon_c;
  logic [15:0] mon_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      grant_beats = 0;
      req_q       = 1'b0;
    end else begin
      if (mem_valid) begin
        grant_beats++;
        chk("beats_per_grant_le_max", 32'(grant_beats <= MAX_BURST), 32'd1);
        chk("beat_expected", 32'(exp_cmd_q.size() != 0), 32'd1);
        if (exp_cmd_q.size() != 0) begin
          mon_c = mem_cmd_t'(exp_cmd_q.pop_front());
          chk("beat_rw", 32'(mem_rw), 32'(mon_c.rw));
          chk("beat_addr", 32'(mem_addr), 32'(mon_c.addr));
          if (mon_c.rw == RW_WRITE) chk("beat_wdata", 32'(mem_wdata), 32'(mon_c.wdata));
        end
      end else begin
        chk("idle_bus_zero", 32'({mem_rw, mem_addr, mem_wdata}), 32'd0);
      end
      if (rsp_valid) begin
        chk("rsp_expected", 32'(exp_rsp_q.size() != 0), 32'd1);
        if (exp_rsp_q.size() != 0) begin
          mon_r = exp_rsp_q.pop_front();
          chk("rsp_addr", 32'(rsp_addr), 32'(mon_r[15:8]));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_r[7:0]));
        end
      end
      if (req_q && !req) begin
        grant_q.push_back(grant_beats);
        grant_beats = 0;
      end
      req_q = req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one command for one cycle; reference updated only if accepted.
  task automatic try_push(input logic rw, input logic [7:0] a, input logic [7:0] d,
                          output bit ok);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    ok = cmd_ready;
    if (ok) begin
      exp_cmd_q.push_back({rw, a, d});
      if (rw == RW_READ) exp_rsp_q.push_back({a, ref_mem[a]});
      else ref_mem[a] = d;
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic rw, input logic [7:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) try_push(rw, a, d, ok);
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_beat;
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = mem_valid;
    end
    chk("beat_seen", 32'(seen), 32'd1);
  endtask

  task automatic drain;
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = (exp_cmd_q.size() == 0) && !busy && !req && !ack;
    end
    chk("drain_done", 32'(done), 32'd1);
    repeat (2) @(negedge clk);
    chk("rsp_all_returned", 32'(exp_rsp_q.size()), 32'd0);
    tick();
  endtask

  task automatic check_grants(input string tag, input int n, input int first, input int second);
    chk({tag, "_grant_count"}, 32'(grant_q.size()), 32'(n));
    if (grant_q.size() >= 1) chk({tag, "_grant0_beats"}, 32'(grant_q[0]), 32'(first));
    if (grant_q.size() >= 2) chk({tag, "_grant1_beats"}, 32'(grant_q[1]), 32'(second));
    grant_q.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : main
    bit ok;
    rst       = 1'b1;
    ack_en    = 1'b0;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_bus", 32'({mem_rw, mem_addr, mem_wdata}), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_rdata, rsp_addr}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    rst = 1'b0;

    // Write then read the same address: read returns the new data
    ack_en = 1'b1;
    push(RW_WRITE, 8'h10, 8'hA5);
    push(RW_READ, 8'h10, 8'h00);
    drain();
    chk("wr_rd_ref_value", 32'(ref_mem[8'h10]), 32'hA5);
    check_grants("wr_rd", 1, 2, 0);

    // Burst limit: six reads split into 4 + 2 across two grants
    for (int i = 0; i < 6; i++) push(RW_READ, 8'(i), 8'h00);
    drain();
    check_grants("burst", 2, 4, 2);

    // FIFO full with no grant: fifth command refused
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++)
      push(1'($urandom_range(0, 1)), 8'($urandom_range(8'h40, 8'h47)), 8'($urandom));
    @(negedge clk);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_req", 32'(req), 32'd1);
    chk("full_state", 32'(dbg_state), 32'(REQ));
    tick();
    try_push(RW_WRITE, 8'h50, 8'h5A, ok);
    chk("full_fifth_rejected", 32'(ok), 32'd0);
    ack_en = 1'b1;
    drain();
    check_grants("full", 1, 4, 0);

    // Grant lost after one beat of a three-command queue
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++)
      push(1'($urandom_range(0, 1)), 8'($urandom_range(8'h60, 8'h63)), 8'($urandom));
    ack_en = 1'b1;
    wait_beat();
    tick();
    ack_en = 1'b0;
    @(negedge clk);
    chk("acklost_mem_valid", 32'(mem_valid), 32'd0);
    chk("acklost_bus_zero", 32'({mem_rw, mem_addr, mem_wdata}), 32'd0);
    chk("acklost_req_held", 32'(req), 32'd1);
    tick();
    @(negedge clk);
    chk("acklost_state", 32'(dbg_state), 32'(REQ));
    tick();
    ack_en = 1'b1;
    drain();
    check_grants("acklost", 1, 3, 0);

    // Reset during the second beat: everything pending is dropped
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) push(RW_READ, 8'($urandom_range(8'h70, 8'h7F)), 8'h00);
    ack_en = 1'b1;
    wait_beat();
    wait_beat();
    #1;
    rst = 1'b1;
    tick();
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    @(negedge clk);
    chk("midrst_req", 32'(req), 32'd0);
    chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    rst = 1'b0;

    // Idle bus: nothing issued without new commands
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_req", 32'(req), 32'd0);
      chk("idle_mem_valid", 32'(mem_valid), 32'd0);
      tick();
    end
    grant_q.delete();

    // Random commands with a grant that comes and goes
    for (int i = 0; i < 80; i++) begin
      ack_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0)
        try_push(1'($urandom_range(0, 1)), 8'($urandom_range(8'h20, 8'h27)), 8'($urandom), ok);
      else
        tick();
    end
    ack_en = 1'b1;
    drain();
    chk("random_cmds_all_issued", 32'(exp_cmd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
